// File: rtl/rf_pkg.sv
// rf_pkg: shared defaults and helpers for the register file with write-pending scoreboard
package rf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W = 2;
  localparam int REG_ZERO = 0;
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction
endpackage

// File: rtl/reg_sb_cnt.sv
// reg_sb_cnt: saturating pending-write counter with sync clear
module reg_sb_cnt #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         full,
  output logic         nonzero
);
  logic [W-1:0] cnt_q, cnt_d;
  assign full = &cnt_q;
  assign nonzero = |cnt_q;
  assign cnt = cnt_q;
  // inc together with dec holds the count, even when saturated or empty
  always_comb cnt_d = clr ? '0 :
                      (inc && !dec && !full) ? cnt_q + 1'b1 :
                      (dec && !inc && nonzero) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read-port register file with per-register pending-write scoreboard
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_W,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int NUM_RD = 2,
  parameter int CNT_WIDTH = CNT_W,
  parameter int BYPASS = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wen,
  input  logic [ADDR_WIDTH-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic                         sb_set,
  input  logic [ADDR_WIDTH-1:0]        sb_addr,
  output logic                         sb_full,
  input  logic                         sb_flush
);
  localparam int DEPTH = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_WIDTH-1:0]  cnt [DEPTH];
  logic [DEPTH-1:0]      full, nonzero;
  logic                  we;
  assign we = wen && waddr != ADDR_WIDTH'(REG_ZERO);
  always_ff @(posedge clk)
    if (rst) for (int k = 0; k < DEPTH; k++) mem_q[k] <= '0;
    else if (we) mem_q[waddr] <= wdata;
  // register 0 carries no counter and is permanently idle
  assign cnt[0] = '0;
  assign full[0] = 1'b0;
  assign nonzero[0] = 1'b0;
  for (genvar i = 1; i < DEPTH; i++) begin : g_cnt
    reg_sb_cnt #(.W(CNT_WIDTH)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .clr     (sb_flush),
      .inc     (sb_set && sb_addr == ADDR_WIDTH'(i)),
      .dec     (we && waddr == ADDR_WIDTH'(i)),
      .cnt     (cnt[i]),
      .full    (full[i]),
      .nonzero (nonzero[i])
    );
  end
  assign sb_full = full[sb_addr];
  for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic                  hit;
    assign ra = raddr[slice_lo(r, ADDR_WIDTH) +: ADDR_WIDTH];
    assign hit = BYPASS != 0 && we && waddr == ra;
    assign rdata[slice_lo(r, DATA_WIDTH) +: DATA_WIDTH] = ra == ADDR_WIDTH'(REG_ZERO) ? '0 :
                                                          hit ? wdata : mem_q[ra];
    // a write landing this cycle retires one reservation early for the reader
    assign rd_busy[r] = hit ? cnt[ra] > CNT_WIDTH'(1) : nonzero[ra];
  end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: random + directed check of reg_file_sb (bypass and non-bypass) against a behavioural model
module tb_reg_file_sb;
  localparam int NR = 4;
  localparam int MAXC = 3;
  logic clk = 0, rst = 0, wen = 0, sb_set = 0, sb_flush = 0;
  logic [4:0] waddr = 0, sb_addr = 0;
  logic [31:0] wdata = 0;
  logic [4:0] ra [NR];
  logic [NR*5-1:0] raddr;
  logic [NR*32-1:0] rdata_b, rdata_n;
  logic [NR-1:0] busy_b, busy_n;
  logic full_b, full_n;
  int n_chk = 0, n_err = 0;
  logic [31:0] mem [32];
  int cnt [32];

  always #5 clk = ~clk;
  assign raddr = {ra[3], ra[2], ra[1], ra[0]};

  reg_file_sb #(.NUM_RD(NR), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .rd_busy(busy_b), .sb_set(sb_set), .sb_addr(sb_addr),
    .sb_full(full_b), .sb_flush(sb_flush));
  reg_file_sb #(.NUM_RD(NR), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_n), .rd_busy(busy_n), .sb_set(sb_set), .sb_addr(sb_addr),
    .sb_full(full_n), .sb_flush(sb_flush));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_data(input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && wen && waddr == a) return wdata;
    return mem[a];
  endfunction

  function automatic logic [31:0] exp_busy(input logic [4:0] a, input bit byp);
    int c;
    if (a == 0) return 0;
    c = cnt[a];
    if (byp && wen && waddr == a && c > 0) c = c - 1;
    return {31'b0, c != 0};
  endfunction

  task automatic check_outputs();
    for (int p = 0; p < NR; p++) begin
      chk($sformatf("rdata_byp[%0d]", p), rdata_b[p*32 +: 32], exp_data(ra[p], 1));
      chk($sformatf("rdata_nob[%0d]", p), rdata_n[p*32 +: 32], exp_data(ra[p], 0));
      chk($sformatf("busy_byp[%0d]", p), {31'b0, busy_b[p]}, exp_busy(ra[p], 1));
      chk($sformatf("busy_nob[%0d]", p), {31'b0, busy_n[p]}, exp_busy(ra[p], 0));
    end
    chk("sb_full_byp", {31'b0, full_b}, {31'b0, sb_addr != 0 && cnt[sb_addr] == MAXC});
    chk("sb_full_nob", {31'b0, full_n}, {31'b0, sb_addr != 0 && cnt[sb_addr] == MAXC});
  endtask

  task automatic model_edge();
    bit s, w;
    if (rst) begin
      for (int k = 0; k < 32; k++) begin mem[k] = 0; cnt[k] = 0; end
      return;
    end
    s = sb_set && sb_addr != 0;
    w = wen && waddr != 0;
    if (w) mem[waddr] = wdata;
    if (sb_flush) begin
      for (int k = 0; k < 32; k++) cnt[k] = 0;
    end else if (!(s && w && sb_addr == waddr)) begin
      if (w && cnt[waddr] > 0) cnt[waddr]--;
      if (s && cnt[sb_addr] < MAXC) cnt[sb_addr]++;
    end
  endtask

  task automatic cycle(input bit do_chk = 1);
    #2;
    if (do_chk) check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 0; wen = 0; sb_set = 0; sb_flush = 0;
  endtask

  task automatic all_ports(input logic [4:0] a);
    for (int p = 0; p < NR; p++) ra[p] = a;
  endtask

  initial begin
    for (int p = 0; p < NR; p++) ra[p] = 0;
    @(negedge clk);
    rst = 1; wen = 1; waddr = 3; wdata = 32'h55; sb_set = 1; sb_addr = 3;
    cycle(0);
    idle();
    for (int a = 0; a < 32; a++) begin all_ports(a[4:0]); cycle(); end
    wen = 1; waddr = 0; wdata = 32'hDEADBEEF; all_ports(0);
    cycle(); idle(); cycle();
    chk("reg0_after_write", rdata_b[31:0], 32'h0);
    wen = 1; waddr = 5; wdata = 32'h12345678; ra[0] = 5;
    #2;
    chk("bypass_same_cycle", rdata_b[31:0], 32'h12345678);
    chk("nobypass_same_cycle", rdata_n[31:0], 32'h0);
    cycle(); idle();
    #2;
    chk("nobypass_next_cycle", rdata_n[31:0], 32'h12345678);
    cycle();
    sb_set = 1; sb_addr = 7; all_ports(7);
    repeat (4) cycle();
    idle();
    #2;
    chk("reg7_saturated_busy", {31'b0, busy_b[0]}, 32'h1);
    for (int k = 0; k < 3; k++) begin wen = 1; waddr = 7; wdata = 32'h700 + k; cycle(); end
    idle(); cycle();
    chk("reg7_busy_cleared", {31'b0, busy_n[0]}, 32'h0);
    sb_set = 1; sb_addr = 9; all_ports(9); cycle();
    wen = 1; waddr = 9; wdata = 32'h99; cycle();
    idle();
    #2;
    chk("set_retire_busy", {31'b0, busy_n[1]}, 32'h1);
    chk("set_retire_data", rdata_n[63:32], 32'h99);
    cycle();
    sb_set = 1;
    for (int k = 0; k < 4; k++) begin sb_addr = (k < 2) ? 5'd3 : 5'd4; cycle(); end
    sb_flush = 1; sb_addr = 3; ra[0] = 3; ra[1] = 4; ra[2] = 9; ra[3] = 7;
    cycle(); idle();
    #2;
    chk("flush_busy", {28'b0, busy_b}, 32'h0);
    wen = 1; waddr = 3; wdata = 32'h333; cycle(); idle(); cycle();
    chk("underflow_data", rdata_n[31:0], 32'h333);
    chk("underflow_busy", {31'b0, busy_n[0]}, 32'h0);
    for (int n = 0; n < 10000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      sb_flush = ($urandom_range(0, 49) == 0);
      wen = $urandom_range(0, 1);
      sb_set = $urandom_range(0, 1);
      waddr = $urandom_range(0, 7);
      sb_addr = $urandom_range(0, 7);
      wdata = $urandom;
      if ($urandom_range(0, 3) == 0) all_ports($urandom_range(0, 7));
      else for (int p = 0; p < NR; p++) ra[p] = $urandom_range(0, 3) == 0 ? waddr : 5'($urandom_range(0, 31));
      cycle();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end
endmodule
